// File: rtl/top_level_pkg.sv
// Shared definitions for the Hamming(16,11) encoder engine.
//   state_t         : controller FSM states
//   NUM_WORDS       : messages encoded per run
//   IN_BASE         : byte address of the first packed input byte
//   OUT_BASE        : byte address of the first encoded output byte
//   hamming_encode  : 11-bit message -> {MSW, LSW} code bytes
package top_level_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    RD_LO = 3'd2,
    RD_HI = 3'd3,
    WR_LO = 3'd4,
    WR_HI = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam int          NUM_WORDS = 15;
  localparam logic [7:0]  IN_BASE   = 8'd0;
  localparam logic [7:0]  OUT_BASE  = 8'd30;

  // d[0] is b1 ... d[10] is b11.
  // LSW = {b4,b3,b2,p4,b1,p2,p1,p0}, MSW = {b11..b5,p8}.
  // p0 is overall parity over data and the four check bits (SECDED).
  function automatic logic [15:0] hamming_encode(input logic [10:0] d);
    logic p8, p4, p2, p1, p0;
    logic [7:0] lsw, msw;
    p8  = ^d[10:4];
    p4  = d[10] ^ d[9] ^ d[8] ^ d[7] ^ d[3] ^ d[2] ^ d[1];
    p2  = d[10] ^ d[9] ^ d[6] ^ d[5] ^ d[3] ^ d[2] ^ d[0];
    p1  = d[10] ^ d[8] ^ d[6] ^ d[4] ^ d[3] ^ d[1] ^ d[0];
    p0  = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
    lsw = {d[3], d[2], d[1], p4, d[0], p2, p1, p0};
    msw = {d[10:4], p8};
    return {msw, lsw};
  endfunction

endpackage

// File: rtl/top_level_data_mem.sv
// data_mem: 256 x 8-bit data memory.
//   clk    : write clock (rising edge)
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address (combinational read)
//   rdata  : read data
// Contents are deliberately not touched by reset so that preloaded data
// and partially written results survive a reset.
module data_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] Core [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      Core[waddr] <= wdata;
    end
  end

  assign rdata = Core[raddr];

endmodule

// File: rtl/top_level_reg_file.sv
// reg_file: 8 x 8-bit working register file.
//   clk     : clock (rising edge)
//   rst_n   : asynchronous active-low reset, clears all registers
//   we      : write enable
//   waddr   : write register index
//   wdata   : write data
//   raddr_a : read index, port A (combinational)
//   rdata_a : read data, port A
//   raddr_b : read index, port B (combinational)
//   rdata_b : read data, port B
module reg_file #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [2:0]        raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [2:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] Registers [0:7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        Registers[i] <= '0;
      end
    end else if (we) begin
      Registers[waddr] <= wdata;
    end
  end

  assign rdata_a = Registers[raddr_a];
  assign rdata_b = Registers[raddr_b];

endmodule

// File: rtl/top_level.sv
// top_level: Hamming(16,11) encoder engine.
// Reads NUM_WORDS packed 11-bit messages from DM1 starting at IN_BASE,
// encodes each through RF1 registers 0/1, and writes the 16-bit codes
// (LSW then MSW) starting at OUT_BASE. Four cycles per word.
//   Clk        : system clock, rising edge
//   Reset      : asynchronous active-low reset
//   Start      : run request; the run begins once it falls
//   Ack        : registered done flag, high while idle after completion
//   CycleCount : (only with CYCLE_COUNT_EN) busy-cycle counter of the
//                last run, saturating at 0xFFFF
// Optional build macro: CYCLE_COUNT_EN.
module top_level
  import top_level_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  output logic        Ack
`ifdef CYCLE_COUNT_EN
  ,
  output logic [15:0] CycleCount
`endif
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_WORDS - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        ack_q, ack_d;

  logic        mem_we;
  logic [7:0]  mem_waddr, mem_wdata, mem_raddr, mem_rdata;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [7:0]  rf_rdata_a, rf_rdata_b;
  logic [15:0] code;
  logic        unused_rf_hi;

  logic [7:0]  word_off, in_lo, out_lo;

  assign word_off = {3'b000, idx_q, 1'b0};
  assign in_lo    = IN_BASE + word_off;
  assign out_lo   = OUT_BASE + word_off;

  data_mem DM1 (
    .clk   (Clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  reg_file RF1 (
    .clk     (Clk),
    .rst_n   (Reset),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (mem_rdata),
    .raddr_a (3'd0),
    .rdata_a (rf_rdata_a),
    .raddr_b (3'd1),
    .rdata_b (rf_rdata_b)
  );

  // Only b11..b9 of the high input byte carry message bits.
  assign code         = hamming_encode({rf_rdata_b[2:0], rf_rdata_a});
  assign unused_rf_hi = ^rf_rdata_b[7:3];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ack_d     = ack_q;
    mem_we    = 1'b0;
    mem_waddr = out_lo;
    mem_wdata = code[7:0];
    mem_raddr = in_lo;
    rf_we     = 1'b0;
    rf_waddr  = 3'd0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = ARMED;
          ack_d   = 1'b0;
          idx_d   = '0;
        end
      end
      ARMED: begin
        // Memory may be preloaded while Start is held.
        if (!Start) begin
          state_d = RD_LO;
        end
      end
      RD_LO: begin
        mem_raddr = in_lo;
        rf_we     = 1'b1;
        rf_waddr  = 3'd0;
        state_d   = RD_HI;
      end
      RD_HI: begin
        mem_raddr = in_lo + 8'd1;
        rf_we     = 1'b1;
        rf_waddr  = 3'd1;
        state_d   = WR_LO;
      end
      WR_LO: begin
        mem_we    = 1'b1;
        mem_waddr = out_lo;
        mem_wdata = code[7:0];
        state_d   = WR_HI;
      end
      WR_HI: begin
        mem_we    = 1'b1;
        mem_waddr = out_lo + 8'd1;
        mem_wdata = code[15:8];
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = RD_LO;
        end
      end
      DONE: begin
        // Ack is set from the DONE state, so it rises one edge after entry.
        ack_d = 1'b1;
        if (Start) begin
          state_d = ARMED;
          ack_d   = 1'b0;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        ack_d   = 1'b0;
        idx_d   = '0;
      end
    endcase
  end

  assign Ack = ack_q;

`ifdef CYCLE_COUNT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        busy;

  assign busy = (state_q == RD_LO) || (state_q == RD_HI) ||
                (state_q == WR_LO) || (state_q == WR_HI);

  always_comb begin
    cnt_d = cnt_q;
    if ((state_d == ARMED) && (state_q != ARMED)) begin
      cnt_d = '0;
    end else if (busy && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign CycleCount = cnt_q;
`endif

endmodule

// File: tb/tb_top_level.sv
// Directed self-checking bench for top_level (Hamming(16,11) encoder engine).
module tb_top_level;
  import top_level_pkg::*;

  logic Clk;
  logic Reset;
  logic Start;
  logic Ack;
`ifdef CYCLE_COUNT_EN
  logic [15:0] CycleCount;
`endif

  int n_chk;
  int n_fail;

  top_level dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .Ack   (Ack)
`ifdef CYCLE_COUNT_EN
    ,
    .CycleCount (CycleCount)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Start pulse of one cycle; returns just after the edge that enters RD_LO.
  task automatic kick();
    Start = 1'b1;
    tick();
    chk("ack_low_after_start", 16'(Ack), 16'd0);
    Start = 1'b0;
    tick();
  endtask

  // Counts edges from RD_LO entry until Ack rises; optionally pokes Start mid-run.
  task automatic run_to_ack(input string tag, input bit poke);
    int n;
    n = 0;
    while (Ack !== 1'b1 && n < 200) begin
      if (poke && n == 10) Start = 1'b1;
      if (poke && n == 11) Start = 1'b0;
      tick();
      n++;
    end
    chk(tag, 16'(n), 16'd61);
`ifdef CYCLE_COUNT_EN
    chk("cycle_count", CycleCount, 16'd60);
`endif
  endtask

  task automatic fill_in(input logic [7:0] lo, input logic [7:0] hi);
    for (int i = 0; i < 15; i++) begin
      dut.DM1.Core[2*i]   = lo;
      dut.DM1.Core[2*i+1] = hi;
    end
  endtask

  task automatic fill_out(input logic [7:0] v);
    for (int i = 30; i < 60; i++) dut.DM1.Core[i] = v;
  endtask

  logic [7:0] exp_lo [0:14];
  logic [7:0] exp_hi [0:14];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    Start  = 1'b0;
    Reset  = 1'b0;
    tick();
    tick();
    chk("rst_ack", 16'(Ack), 16'd0);
    chk("rst_state", 16'(dut.state_q), 16'(IDLE));
    chk("rst_reg0", 16'(dut.RF1.Registers[0]), 16'd0);
`ifdef CYCLE_COUNT_EN
    chk("rst_count", CycleCount, 16'd0);
`endif
    #3 Reset = 1'b1;

    // Run A: all-zero inputs.
    fill_in(8'h00, 8'h00);
    fill_out(8'hAA);
    tick();
    kick();
    chk("rd_lo_entry", 16'(dut.state_q), 16'(RD_LO));
    run_to_ack("ack_latency_a", 1'b0);
    for (int i = 30; i < 60; i++) chk($sformatf("zero_out[%0d]", i), 16'(dut.DM1.Core[i]), 16'h00);
    chk("ack_high_a", 16'(Ack), 16'd1);

    // Run B: directed vectors, back-to-back from DONE, Start poked mid-run.
    fill_in(8'h00, 8'h00);
    fill_out(8'hAA);
    dut.DM1.Core[0] = 8'hFF; dut.DM1.Core[1] = 8'h07;
    dut.DM1.Core[2] = 8'h01; dut.DM1.Core[3] = 8'h00;
    dut.DM1.Core[4] = 8'h00; dut.DM1.Core[5] = 8'h04;
    dut.DM1.Core[6] = 8'h00; dut.DM1.Core[7] = 8'hFC;
    dut.DM1.Core[8] = 8'h55; dut.DM1.Core[9] = 8'h05;
    for (int i = 0; i < 15; i++) begin
      exp_lo[i] = 8'h00;
      exp_hi[i] = 8'h00;
    end
    exp_lo[0] = 8'hFF; exp_hi[0] = 8'hFF;
    exp_lo[1] = 8'h0F; exp_hi[1] = 8'h00;
    exp_lo[2] = 8'h17; exp_hi[2] = 8'h81;
    exp_lo[3] = 8'h17; exp_hi[3] = 8'h81;
    exp_lo[4] = 8'h5A; exp_hi[4] = 8'hAA;
    kick();
    run_to_ack("ack_latency_b", 1'b1);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("vec_lo[%0d]", i), 16'(dut.DM1.Core[30+2*i]), 16'(exp_lo[i]));
      chk($sformatf("vec_hi[%0d]", i), 16'(dut.DM1.Core[31+2*i]), 16'(exp_hi[i]));
    end

    // Run C: reset during word 7, then a fresh run.
    fill_in(8'hFF, 8'h07);
    fill_out(8'hAA);
    kick();
    repeat (30) tick();
    chk("mid_idx", 16'(dut.idx_q), 16'd7);
    Reset = 1'b0;
    #1;
    chk("mid_rst_ack", 16'(Ack), 16'd0);
    chk("mid_rst_state", 16'(dut.state_q), 16'(IDLE));
    chk("mid_rst_idx", 16'(dut.idx_q), 16'd0);
    chk("mid_rst_reg0", 16'(dut.RF1.Registers[0]), 16'd0);
    for (int i = 30; i < 44; i++) chk($sformatf("kept[%0d]", i), 16'(dut.DM1.Core[i]), 16'hFF);
    for (int i = 44; i < 60; i++) chk($sformatf("unwritten[%0d]", i), 16'(dut.DM1.Core[i]), 16'hAA);
    #2 Reset = 1'b1;
    fill_in(8'h01, 8'h00);
    tick();
    kick();
    run_to_ack("ack_latency_c", 1'b0);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("fresh_lo[%0d]", i), 16'(dut.DM1.Core[30+2*i]), 16'h0F);
      chk($sformatf("fresh_hi[%0d]", i), 16'(dut.DM1.Core[31+2*i]), 16'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
